// File: rtl/typedefs.sv
// ============================================================================
//  Package    : typedefs
//  Description: Shared dispatch/issue types: reservation-station entry,
//               completion broadcast bus and functional-unit encoding.
//  Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

package typedefs;

   localparam int RS_DEPTH = 16;
   localparam int ROB_W    = 4;
   localparam int TAG_W    = 6;
   localparam int DATA_W   = 32;

   typedef enum logic [1:0] {
      FU_ALU0 = 2'b00,
      FU_ALU1 = 2'b01,
      FU_MEM  = 2'b10
   } fu_e;

   typedef struct packed {
      logic [7:0]       opcode;
      logic [TAG_W-1:0] rd;
      logic [TAG_W-1:0] rs1;
      logic [TAG_W-1:0] rs2;
   } instStruct;

   typedef struct packed {
      logic              valid;
      logic [ROB_W-1:0]  robNum;
      logic [1:0]        fu;
      instStruct         instruction;
      logic              src1rdy;
      logic [DATA_W-1:0] src1val;
      logic              src2rdy;
      logic [DATA_W-1:0] src2val;
   } rsEntry;

   typedef struct packed {
      logic              valid;
      logic [TAG_W-1:0]  tag;
      logic [DATA_W-1:0] data;
   } cdbStruct;

   // 2'b11 has no functional unit behind it
   function automatic logic fu_legal(input logic [1:0] fu);
      return (fu == FU_ALU0) || (fu == FU_ALU1) || (fu == FU_MEM);
   endfunction

endpackage

`default_nettype wire

// File: rtl/rs_select.sv
// ============================================================================
//  Module     : rs_select
//  Description: Age picker. Returns the ready slot whose distance from
//               rob_head (modulo the table size) is smallest.
//  Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module rs_select
   import typedefs::*;
(
   input  logic [RS_DEPTH-1:0] ready_mask,
   input  logic [ROB_W-1:0]    rob_head,
   output logic                found,
   output logic [ROB_W-1:0]    index
);

   logic [ROB_W-1:0] cand;

   // Walk slots in age order starting at rob_head; the first ready one is the oldest
   always_comb begin
      found = 1'b0;
      index = '0;
      cand  = '0;
      for (int off = 0; off < RS_DEPTH; off++) begin
         cand = rob_head + ROB_W'(off);
         if (!found && ready_mask[cand]) begin
            found = 1'b1;
            index = cand;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/rs_table.sv
// ============================================================================
//  Module     : rs_table
//  Description: Reservation station. Two dispatch writes per cycle indexed by
//               robNum, CDB wakeup with write-time forwarding, and one
//               oldest-first issue per functional unit under valid/ready.
//  Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module rs_table
   import typedefs::*;
#(
   parameter int N_CDB = 3
)(
   input  logic             clk,
   input  logic             reset,
   input  rsEntry           rsLine_a,
   input  rsEntry           rsLine_b,
   input  cdbStruct         cdb [N_CDB],
   input  logic [ROB_W-1:0] rob_head,
   output rsEntry           issue [3],
   output logic [2:0]       issue_valid,
   input  logic [2:0]       fu_ready,
   output logic [4:0]       rs_free,
   output logic             overflow
);

   localparam int N_FU = 3;

   rsEntry              slot_q [RS_DEPTH];
   rsEntry              slot_d [RS_DEPTH];
   logic                overflow_q, overflow_d;
   logic [4:0]          rs_free_q, rs_free_d;

   logic [RS_DEPTH-1:0] ready_mask [N_FU];
   logic [N_FU-1:0]     sel_found;
   logic [ROB_W-1:0]    sel_idx [N_FU];

   // Capture broadcast data into any non-ready source; descending scan lets
   // the lowest-numbered matching bus win.
   function automatic rsEntry capture(input rsEntry e, input cdbStruct bus [N_CDB]);
      rsEntry r;
      r = e;
      for (int k = N_CDB - 1; k >= 0; k--) begin
         if (bus[k].valid && !e.src1rdy && (bus[k].tag == e.instruction.rs1)) begin
            r.src1rdy = 1'b1;
            r.src1val = bus[k].data;
         end
         if (bus[k].valid && !e.src2rdy && (bus[k].tag == e.instruction.rs2)) begin
            r.src2rdy = 1'b1;
            r.src2val = bus[k].data;
         end
      end
      return r;
   endfunction

   // Per-FU ready masks from the registered table
   always_comb begin
      for (int i = 0; i < N_FU; i++) begin
         for (int s = 0; s < RS_DEPTH; s++) begin
            ready_mask[i][s] = slot_q[s].valid && slot_q[s].src1rdy &&
                               slot_q[s].src2rdy && (slot_q[s].fu == 2'(i));
         end
      end
   end

   for (genvar g = 0; g < N_FU; g++) begin : g_sel
      rs_select u_sel (
         .ready_mask (ready_mask[g]),
         .rob_head   (rob_head),
         .found      (sel_found[g]),
         .index      (sel_idx[g])
      );
   end

   // Issue outputs; held at zero while reset is asserted
   always_comb begin
      for (int i = 0; i < N_FU; i++) begin
         issue_valid[i] = reset && sel_found[i];
         issue[i]       = (reset && sel_found[i]) ? slot_q[sel_idx[i]] : '0;
      end
   end

   // Next table: wakeup, retire accepted issues, then dispatch writes (b last so it wins)
   always_comb begin
      slot_d     = slot_q;
      overflow_d = overflow_q;

      for (int s = 0; s < RS_DEPTH; s++) begin
         if (slot_q[s].valid) begin
            slot_d[s] = capture(slot_q[s], cdb);
         end
      end

      for (int i = 0; i < N_FU; i++) begin
         if (issue_valid[i] && fu_ready[i]) begin
            slot_d[sel_idx[i]].valid = 1'b0;
         end
      end

      if (rsLine_a.valid) begin
         if (slot_q[rsLine_a.robNum].valid || !fu_legal(rsLine_a.fu)) begin
            overflow_d = 1'b1;
         end
         slot_d[rsLine_a.robNum] = capture(rsLine_a, cdb);
      end

      if (rsLine_b.valid) begin
         if (slot_q[rsLine_b.robNum].valid || !fu_legal(rsLine_b.fu) ||
             (rsLine_a.valid && (rsLine_a.robNum == rsLine_b.robNum))) begin
            overflow_d = 1'b1;
         end
         slot_d[rsLine_b.robNum] = capture(rsLine_b, cdb);
      end

      rs_free_d = 5'(RS_DEPTH);
      for (int s = 0; s < RS_DEPTH; s++) begin
         if (slot_d[s].valid) begin
            rs_free_d = rs_free_d - 5'd1;
         end
      end
   end

   // Table state registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int s = 0; s < RS_DEPTH; s++) begin
            slot_q[s] <= '0;
         end
         overflow_q <= 1'b0;
         rs_free_q  <= 5'(RS_DEPTH);
      end else begin
         slot_q     <= slot_d;
         overflow_q <= overflow_d;
         rs_free_q  <= rs_free_d;
      end
   end

   assign rs_free  = rs_free_q;
   assign overflow = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_rs_table.sv
// ============================================================================
//  Module     : tb_rs_table
//  Description: Scoreboard bench for rs_table. A behavioural table model
//               predicts each cycle's issue outputs, rs_free and overflow;
//               a monitor process pops and compares them.
//  Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rs_table;
   import typedefs::*;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset;
   rsEntry     line_a, line_b;
   cdbStruct   cdb_in [3];
   logic [3:0] rob_head;
   rsEntry     dut_issue [3];
   logic [2:0] issue_valid;
   logic [2:0] fu_ready;
   logic [4:0] rs_free;
   logic       overflow;

   rs_table #(.N_CDB(3)) dut (
      .clk         (clk),
      .reset       (reset),
      .rsLine_a    (line_a),
      .rsLine_b    (line_b),
      .cdb         (cdb_in),
      .rob_head    (rob_head),
      .issue       (dut_issue),
      .issue_valid (issue_valid),
      .fu_ready    (fu_ready),
      .rs_free     (rs_free),
      .overflow    (overflow)
   );

   typedef struct packed {
      logic [2:0]       iv;
      rsEntry [2:0]     ent;
      logic [4:0]       free;
      logic             ovf;
   } exp_t;

   exp_t   exp_q [$];
   int     n_cmp = 0;
   int     n_bad = 0;

   // reference model: slot contents and sticky error flag
   rsEntry m_tab [16];
   logic   m_ovf;

   task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", nm, got, want, $time);
      end
   endtask

   function automatic rsEntry mk(input int rob, input int fu, input int rs1, input int rs2,
                                 input bit r1, input bit r2, input logic [31:0] v1,
                                 input logic [31:0] v2);
      rsEntry r;
      r = '0;
      r.valid           = 1'b1;
      r.robNum          = 4'(rob);
      r.fu              = 2'(fu);
      r.instruction.rs1 = 6'(rs1);
      r.instruction.rs2 = 6'(rs2);
      r.src1rdy         = r1;
      r.src2rdy         = r2;
      r.src1val         = v1;
      r.src2val         = v2;
      return r;
   endfunction

   // Source capture from the broadcast buses: first matching bus wins
   function automatic rsEntry fwd(input rsEntry e);
      rsEntry r;
      bit d1, d2;
      r = e; d1 = 0; d2 = 0;
      for (int k = 0; k < 3; k++) begin
         if (cdb_in[k].valid) begin
            if (!e.src1rdy && !d1 && cdb_in[k].tag == e.instruction.rs1) begin
               r.src1rdy = 1'b1; r.src1val = cdb_in[k].data; d1 = 1;
            end
            if (!e.src2rdy && !d2 && cdb_in[k].tag == e.instruction.rs2) begin
               r.src2rdy = 1'b1; r.src2val = cdb_in[k].data; d2 = 1;
            end
         end
      end
      return r;
   endfunction

   // Oldest ready slot for FU f: smallest (slot - rob_head) mod 16
   function automatic int pick(input int f);
      int best, best_age, age;
      best = -1; best_age = 1000;
      for (int s = 0; s < 16; s++) begin
         if (m_tab[s].valid && m_tab[s].src1rdy && m_tab[s].src2rdy && int'(m_tab[s].fu) == f) begin
            age = (s - int'(rob_head) + 16) % 16;
            if (age < best_age) begin
               best_age = age; best = s;
            end
         end
      end
      return best;
   endfunction

   // Predict this cycle's outputs, advance the model across the edge, move to next negedge
   task automatic tick();
      exp_t   e;
      int     sel [3];
      int     nfree;
      rsEntry nt [16];
      nfree = 16;
      for (int s = 0; s < 16; s++) if (m_tab[s].valid) nfree--;
      for (int i = 0; i < 3; i++) begin
         sel[i]   = reset ? pick(i) : -1;
         e.iv[i]  = (sel[i] >= 0);
         e.ent[i] = (sel[i] >= 0) ? m_tab[sel[i]] : '0;
      end
      e.free = 5'(nfree);
      e.ovf  = m_ovf;
      exp_q.push_back(e);

      if (!reset) begin
         for (int s = 0; s < 16; s++) m_tab[s] = '0;
         m_ovf = 1'b0;
      end else begin
         for (int s = 0; s < 16; s++) nt[s] = m_tab[s].valid ? fwd(m_tab[s]) : m_tab[s];
         for (int i = 0; i < 3; i++) if (sel[i] >= 0 && fu_ready[i]) nt[sel[i]].valid = 1'b0;
         if (line_a.valid) begin
            if (m_tab[line_a.robNum].valid || line_a.fu == 2'b11) m_ovf = 1'b1;
            nt[line_a.robNum] = fwd(line_a);
         end
         if (line_b.valid) begin
            if (m_tab[line_b.robNum].valid || line_b.fu == 2'b11 ||
                (line_a.valid && line_a.robNum == line_b.robNum)) m_ovf = 1'b1;
            nt[line_b.robNum] = fwd(line_b);
         end
         for (int s = 0; s < 16; s++) m_tab[s] = nt[s];
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle();
      line_a = '0;
      line_b = '0;
      for (int k = 0; k < 3; k++) cdb_in[k] = '0;
      fu_ready = 3'b000;
   endtask

   function automatic rsEntry rnd_line();
      rsEntry r;
      r.valid               = ($urandom_range(0, 99) < 45);
      r.robNum              = 4'($urandom_range(0, 15));
      r.fu                  = ($urandom_range(0, 49) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      r.instruction.opcode  = 8'($urandom);
      r.instruction.rd      = 6'($urandom);
      r.instruction.rs1     = 6'($urandom_range(0, 15));
      r.instruction.rs2     = 6'($urandom_range(0, 15));
      r.src1rdy             = 1'($urandom_range(0, 1));
      r.src1val             = $urandom;
      r.src2rdy             = 1'($urandom_range(0, 1));
      r.src2val             = $urandom;
      return r;
   endfunction

   // Monitor: compare DUT outputs against each queued prediction
   initial begin
      exp_t e;
      forever begin
         wait (exp_q.size() != 0);
         #1;
         e = exp_q.pop_front();
         chk("issue_valid", 128'(issue_valid), 128'(e.iv));
         for (int i = 0; i < 3; i++)
            chk($sformatf("issue[%0d]", i), 128'(dut_issue[i]), 128'(e.ent[i]));
         chk("rs_free", 128'(rs_free), 128'(e.free));
         chk("overflow", 128'(overflow), 128'(e.ovf));
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete, got timeout want finish");
      $fatal(1, "watchdog");
   end

   // Stimulus: directed scenarios then randomized traffic
   initial begin
      for (int s = 0; s < 16; s++) m_tab[s] = '0;
      m_ovf    = 1'b0;
      idle();
      reset    = 1'b0;
      rob_head = 4'd0;
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("reset_iv", 128'(issue_valid), 128'(3'b000));
      chk("reset_free", 128'(rs_free), 128'(5'd16));
      chk("reset_ovf", 128'(overflow), 128'(1'b0));
      tick();

      // two ready entries, ALU0 and MEM
      reset  = 1'b1;
      line_a = mk(0, 0, 1, 2, 1, 1, 32'h11, 32'h22);
      line_b = mk(1, 2, 3, 4, 1, 1, 32'h33, 32'h44);
      tick();
      idle();
      fu_ready = 3'b101;
      #1;
      chk("t1_iv", 128'(issue_valid), 128'(3'b101));
      chk("t1_free", 128'(rs_free), 128'(5'd14));
      tick();
      idle();
      #1;
      chk("t1_free_after", 128'(rs_free), 128'(5'd16));
      tick();

      // CDB wakeup of stored ALU1 entry
      line_a = mk(2, 1, 9, 0, 0, 1, 32'h0, 32'h77);
      tick();
      idle();
      cdb_in[1] = '{valid: 1'b1, tag: 6'd9, data: 32'hDEAD_BEEF};
      #1;
      chk("t2_not_yet", 128'(issue_valid[1]), 128'(1'b0));
      tick();
      idle();
      fu_ready = 3'b010;
      #1;
      chk("t2_iv", 128'(issue_valid[1]), 128'(1'b1));
      chk("t2_val", 128'(dut_issue[1].src1val), 128'(32'hDEAD_BEEF));
      tick();

      // write-time forwarding on src2
      idle();
      line_a = mk(5, 0, 0, 5, 1, 0, 32'h1, 32'h0);
      cdb_in[0] = '{valid: 1'b1, tag: 6'd5, data: 32'h1234};
      tick();
      idle();
      fu_ready = 3'b001;
      #1;
      chk("t3_iv", 128'(issue_valid[0]), 128'(1'b1));
      chk("t3_rdy", 128'(dut_issue[0].src2rdy), 128'(1'b1));
      chk("t3_val", 128'(dut_issue[0].src2val), 128'(32'h1234));
      tick();

      // age wrap with rob_head = 14
      idle();
      rob_head = 4'd14;
      line_a = mk(1, 0, 0, 0, 1, 1, 32'hA1, 32'hA2);
      line_b = mk(15, 0, 0, 0, 1, 1, 32'hB1, 32'hB2);
      tick();
      idle();
      fu_ready = 3'b001;
      #1;
      chk("t4_first", 128'(dut_issue[0].robNum), 128'(4'd15));
      tick();
      fu_ready = 3'b001;
      #1;
      chk("t4_second", 128'(dut_issue[0].robNum), 128'(4'd1));
      tick();
      idle();
      rob_head = 4'd0;

      // backpressure on ALU0
      line_a = mk(3, 0, 0, 0, 1, 1, 32'hC1, 32'hC2);
      tick();
      idle();
      for (int c = 0; c < 3; c++) begin
         #1;
         chk("t5_hold", 128'({issue_valid[0], dut_issue[0].robNum}), 128'({1'b1, 4'd3}));
         tick();
      end
      fu_ready = 3'b001;
      #1;
      chk("t5_accept", 128'(issue_valid[0]), 128'(1'b1));
      tick();
      idle();
      #1;
      chk("t5_cleared", 128'(issue_valid[0]), 128'(1'b0));
      chk("t5_ovf_clean", 128'(overflow), 128'(1'b0));
      tick();

      // overflow on occupied slot, then reset
      line_a = mk(4, 0, 7, 0, 0, 1, 32'h0, 32'h0);
      tick();
      line_a = mk(4, 1, 7, 0, 0, 1, 32'h0, 32'h0);
      tick();
      idle();
      #1;
      chk("t6_ovf", 128'(overflow), 128'(1'b1));
      tick();
      tick();
      #1;
      chk("t6_sticky", 128'(overflow), 128'(1'b1));
      reset = 1'b0;
      tick();
      reset = 1'b1;
      #1;
      chk("t6_free", 128'(rs_free), 128'(5'd16));
      chk("t6_ovf_clr", 128'(overflow), 128'(1'b0));
      tick();

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         reset    = ($urandom_range(0, 199) != 0);
         line_a   = rnd_line();
         line_b   = rnd_line();
         for (int k = 0; k < 3; k++) begin
            cdb_in[k].valid = ($urandom_range(0, 1) == 1);
            cdb_in[k].tag   = 6'($urandom_range(0, 15));
            cdb_in[k].data  = $urandom;
         end
         rob_head = 4'($urandom_range(0, 15));
         fu_ready = 3'($urandom_range(0, 7));
         tick();
      end

      idle();
      reset = 1'b1;
      tick();
      #3;
      chk("queue_drained", 128'(exp_q.size()), 128'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/rs_table.md
# rs_table

Reservation station at the receiving end of dispatch. Each cycle it accepts up to two `rsEntry` lines (`rsLine_a`, `rsLine_b`) into slots indexed by `robNum`. It wakes waiting sources from the completion broadcast buses and issues at most one ready entry per functional unit (ALU0, ALU1, MEM) per cycle, oldest first, under a valid/ready handshake. It sits between dispatch and the FUs, and is the consumer of the physical-register readiness state that dispatch clears.

## Interface
- `RS_DEPTH`, 16: slot count; equals the `robNum` range (4-bit index).
- `N_CDB`, 3: completion broadcast buses, one per FU.
- `clk` in 1: clock.
- `reset` in 1: one clock; reset is synchronous and active-low.
- `rsLine_a`, `rsLine_b` in `rsEntry`: dispatch lines; a line is written only when its `.valid`=1.
- `cdb[N_CDB]` in `cdbStruct`: `{valid, tag[5:0], data[31:0]}` result broadcast.
- `rob_head` in 4: `robNum` of the oldest in-flight instruction; the age origin.
- `issue[3]` out `rsEntry`: per-FU issued entry; index 0=ALU0, 1=ALU1, 2=MEM.
- `issue_valid[3]` out 1: `issue[i]` holds a ready entry.
- `fu_ready[3]` in 1: FU i accepts this cycle.
- `rs_free` out 5: count of empty slots, 0..16.
- `overflow` out 1: sticky flag; dispatch wrote a valid slot or an illegal `fu`.

## Operation
- Slot state: the full `rsEntry`, including valid, src1rdy/src1val, src2rdy/src2val, fu.
- Write: slot[`rsLine_x.robNum`] <= `rsLine_x`. If `a` and `b` target the same slot, `b` wins and `overflow` is set.
- Write-time forwarding: if a source has rdy=0 and any `cdb[k].valid` with `cdb[k].tag` == the source register (`instruction.rs1`/`rs2`) in the same cycle, store rdy=1 and val=`cdb[k].data`.
- Wakeup: for every valid slot, each non-ready source is compared against all `cdb` buses.
  - On a match, set rdy=1 and capture data.
  - If several buses match, the lowest k wins.
  - Ready sources are never overwritten.
- Ready means valid && src1rdy && src2rdy. Immediates arrive with src2rdy=1.
- Select, per FU i: among ready slots with `fu`==i, pick the minimum of (`robNum` − `rob_head`) mod 16.
  - Drive `issue[i]` and `issue_valid[i]`=1. If no slot qualifies, `issue_valid[i]`=0 and `issue[i]`='0.
- Retire: on `issue_valid[i] && fu_ready[i]`, clear that slot's valid at the edge. An unaccepted entry stays and is re-evaluated next cycle; a newly ready older entry may displace it.
- `fu`==2'b11: the slot is written but never issued; `overflow` is set.
- Writing an already-valid slot: overwrite and set `overflow`. Dispatch never stalls, so this marks a sizing error.
- `rs_free` = 16 − popcount(valid), registered from the current table.

## Timing
- Reset (`reset`=0 at an edge) clears all slot valid bits, `overflow`=0, `rs_free`=16.
  - During reset, `issue_valid` is forced to 0 and `issue` to '0.
  - Dispatch and cdb inputs are ignored while `reset`=0.
  - Reset mid-operation drops all entries.
- The table updates on the posedge. Issue outputs are combinational from the registered table.
- Dispatch at edge N, with both sources ready or forwarded: `issue_valid` is high during cycle N+1. There is no same-cycle dispatch-to-issue.
- CDB wakeup in cycle M for a stored entry: issuable in cycle M+1.
- Issue accepted in cycle M: slot empty from M+1. `rs_free` reflects it in M+1; the same slot may be re-dispatched at edge M+1.
- A dispatch write and an issue-clear of the same slot at one edge: the write wins and `overflow` is set.
- Age wrap: with `rob_head`=14, slot 15 is older than slot 1.

## Structure
- Shared package `typedefs`:
  - add `RS_DEPTH`;
  - add a `cdbStruct`;
  - add the FU enum {FU_ALU0=2'b00, FU_ALU1=2'b01, FU_MEM=2'b10}.
  - `rsEntry` is reused unchanged.
- Sub-module `rs_select`: a 16-way age picker, given ready mask and `rob_head`, returns `found` and a 4-bit index. It is instantiated three times, once per FU, with masks pre-filtered by `fu`.

## Test plan
- Reset, then dispatch `a`: robNum 0, ALU0, both rdy. Dispatch `b`: robNum 1, MEM, both rdy. Expect cycle N+1 `issue_valid`=3'b101 and `rs_free`=14. Hold `fu_ready`=3'b101 one cycle; then `rs_free`=16.
- Dispatch an ALU1 entry with src1 rs1=tag 9 not ready. Next cycle `cdb[1]`={1,9,32'hDEAD_BEEF}. Expect issue the following cycle with src1val=32'hDEAD_BEEF.
- Dispatch with rs2=tag 5 not ready while `cdb[0]`={1,5,32'h1234} in the same cycle. Expect src2rdy=1, src2val=32'h1234, issue at N+1.
- `rob_head`=14; ready ALU0 entries in slots 15 and 1. Expect slot 15 issued first, slot 1 the next cycle.
- `fu_ready[0]`=0 for 3 cycles with slot 3 ready. Expect `issue_valid[0]` held with the same entry; it is cleared one cycle after `fu_ready` rises.
- Dispatch to an occupied slot 4. Expect `overflow`=1 stays set until reset; `reset`=0 for one edge clears all and `rs_free`=16.
